// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C target types and widths
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int BYTE_W     = 8;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } i2c_state_e;
endpackage

// File: rtl/dff.sv
// rtl/dff.sv - storage flop with synchronous active-high reset to a fixed value
module dff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset) q <= RST_VAL;
    else       q <= d;
  end
endmodule

// File: rtl/i2c_bus_sampler.sv
// rtl/i2c_bus_sampler.sv - synchronizes SCL/SDA and flags SCL edges and START/STOP
module i2c_bus_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_cond,
  output logic stop_cond
);
  logic [SYNC_STAGES:0] scl_chain, sda_chain;
  logic scl_s, scl_prev, sda_prev;

  assign scl_chain[0] = scl_i;
  assign sda_chain[0] = sda_i;

  // Everything resets to 1 so an idle bus produces no edges after reset.
  for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
    dff #(.W(2), .RST_VAL(2'b11)) u_sync (
      .clk(clk), .reset(reset),
      .d({scl_chain[i], sda_chain[i]}),
      .q({scl_chain[i+1], sda_chain[i+1]})
    );
  end

  assign scl_s = scl_chain[SYNC_STAGES];
  assign sda_s = sda_chain[SYNC_STAGES];

  dff #(.W(2), .RST_VAL(2'b11)) u_prev (
    .clk(clk), .reset(reset), .d({scl_s, sda_s}), .q({scl_prev, sda_prev})
  );

  assign scl_rise   = scl_s & ~scl_prev;
  assign scl_fall   = ~scl_s & scl_prev;
  assign start_cond = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_cond  = scl_s & scl_prev & ~sda_prev & sda_s;
endmodule

// File: rtl/i2c_target_receiver.sv
// rtl/i2c_target_receiver.sv - I2C target: address match, write receive, read serialize
module i2c_target_receiver import i2c_pkg::*; #(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_load,
  output logic              addr_match,
  output logic              start_det,
  output logic              stop_det,
  output logic              nack_det,
  output logic              busy
);
  logic sda_s, scl_rise, scl_fall, start_cond, stop_cond;

  i2c_bus_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .clk(clk), .reset(reset), .scl_i(scl_i), .sda_i(sda_i), .sda_s(sda_s),
    .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_cond(start_cond), .stop_cond(stop_cond)
  );

  logic [2:0]        state_q;
  i2c_state_e        state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic [6:0]        sh, sh_d, tx_sh, tx_d;
  logic [BYTE_W-1:0] rxd_d;
  logic rw, rw_d, oe_d, am_d, busy_d, rxv_d, txl_d, sd_d, pd_d, nk_d;

  assign state = i2c_state_e'(state_q);

  dff #(.W(3), .RST_VAL(3'(IDLE))) u_state (.clk(clk), .reset(reset), .d(3'(state_d)), .q(state_q));
  dff #(.W(4)) u_cnt   (.clk(clk), .reset(reset), .d(cnt_d),  .q(cnt));
  dff #(.W(7)) u_sh    (.clk(clk), .reset(reset), .d(sh_d),   .q(sh));
  dff #(.W(7)) u_tx    (.clk(clk), .reset(reset), .d(tx_d),   .q(tx_sh));
  dff #(.W(8)) u_rxd   (.clk(clk), .reset(reset), .d(rxd_d),  .q(rx_data));
  dff #(.W(1)) u_rw    (.clk(clk), .reset(reset), .d(rw_d),   .q(rw));
  dff #(.W(1)) u_oe    (.clk(clk), .reset(reset), .d(oe_d),   .q(sda_oe));
  dff #(.W(1)) u_am    (.clk(clk), .reset(reset), .d(am_d),   .q(addr_match));
  dff #(.W(1)) u_busy  (.clk(clk), .reset(reset), .d(busy_d), .q(busy));
  dff #(.W(5)) u_pulse (.clk(clk), .reset(reset), .d({rxv_d, txl_d, sd_d, pd_d, nk_d}),
                        .q({rx_valid, tx_load, start_det, stop_det, nack_det}));

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sh_d    = sh;
    tx_d    = tx_sh;
    rxd_d   = rx_data;
    rw_d    = rw;
    oe_d    = sda_oe;
    am_d    = addr_match;
    busy_d  = busy;
    rxv_d   = 1'b0;
    txl_d   = 1'b0;
    sd_d    = 1'b0;
    pd_d    = 1'b0;
    nk_d    = 1'b0;
    if (stop_cond) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      am_d    = 1'b0;
      busy_d  = 1'b0;
      pd_d    = 1'b1;
    end else if (start_cond) begin
      state_d = ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
      am_d    = 1'b0;
      busy_d  = 1'b1;
      sd_d    = 1'b1;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR: if (scl_rise) begin
          sh_d  = {sh[5:0], sda_s};
          cnt_d = cnt + 4'd1;
          if (cnt == 4'd7) begin
            rw_d    = sda_s;
            state_d = (sh == TARGET_ADDR) ? ADDR_ACK : WAIT_STOP;
          end
        end
        // sda_oe doubles as the ACK-slot phase: low before the slot, high inside it.
        ADDR_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            oe_d = 1'b1;
            am_d = 1'b1;
          end else begin
            cnt_d = '0;
            if (rw) begin
              txl_d   = 1'b1;
              tx_d    = tx_data[6:0];
              oe_d    = ~tx_data[7];
              state_d = RD_DATA;
            end else begin
              oe_d    = 1'b0;
              state_d = WR_DATA;
            end
          end
        end
        WR_DATA: if (scl_rise) begin
          sh_d  = {sh[5:0], sda_s};
          cnt_d = cnt + 4'd1;
          if (cnt == 4'd7) begin
            rxd_d   = {sh, sda_s};
            rxv_d   = 1'b1;
            state_d = WR_ACK;
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!sda_oe) oe_d = 1'b1;
          else begin
            oe_d    = 1'b0;
            cnt_d   = '0;
            state_d = WR_DATA;
          end
        end
        RD_DATA: if (scl_fall) begin
          cnt_d = cnt + 4'd1;
          if (cnt == 4'd7) begin
            oe_d    = 1'b0;
            state_d = RD_ACK;
          end else begin
            oe_d = ~tx_sh[6];
            tx_d = {tx_sh[5:0], 1'b0};
          end
        end
        // A fall here can only follow an ACK rise; a NACK rise has already left.
        RD_ACK: if (scl_rise && sda_s) begin
          nk_d    = 1'b1;
          state_d = WAIT_STOP;
        end else if (scl_fall) begin
          cnt_d   = '0;
          txl_d   = 1'b1;
          tx_d    = tx_data[6:0];
          oe_d    = ~tx_data[7];
          state_d = RD_DATA;
        end
        WAIT_STOP: oe_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: doc/i2c_target_receiver.md
Name: i2c_target_receiver

Overview:
- I2C target (slave) engine: the far end of the bus from the master's SCL generator and byte engine.
- Samples externally driven SCL/SDA, detects START/STOP, matches a 7-bit address and receives write bytes.
- For reads, serializes bytes onto SDA; SDA is open-drain, driven only low.
- Bench companion to the APB I2C master: loops back against it, and gives a synthesizable target model.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit address this target ACKs.
- SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i (minimum 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- scl_i  input  1  bus SCL level (asynchronous).
- sda_i  input  1  bus SDA level (asynchronous).
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- rx_data  output  8  last received write byte, held until next rx_valid.
- rx_valid  output  1  one-clk pulse, rx_data updated.
- tx_data  input  8  byte to send on a read; sampled on tx_load.
- tx_load  output  1  one-clk pulse when tx_data is captured.
- addr_match  output  1  high from address ACK until STOP or repeated START.
- start_det  output  1  one-clk pulse on START or repeated START.
- stop_det  output  1  one-clk pulse on STOP.
- nack_det  output  1  one-clk pulse when master NACKs a read byte.
- busy  output  1  high from START to STOP.

Behaviour:
- Reset: every output 0; FSM = IDLE; bit counter = 0; synchronizers and previous-level flops = 1 (idle bus).
- Input path:
  - scl_s/sda_s = SYNC_STAGES-flop synchronized levels.
  - Edges come from comparing against a registered previous level.
  - Pin-to-event latency = SYNC_STAGES+1 clk.
- START: sda_s falls while scl_s = 1. STOP: sda_s rises while scl_s = 1. Evaluated in every state, with priority over bit activity.
- SCL rise = sample point. SCL fall = sda_oe update point; sda_oe is registered and changes 1 clk after the detected fall.
- States:
  - IDLE: on START, go to ADDR.
  - ADDR: shift sda_s MSB-first on 8 rises; bit 8 = R/W. On the 8th rise:
    - address == TARGET_ADDR: go to ADDR_ACK.
    - otherwise: go to WAIT_STOP, never drive SDA.
  - ADDR_ACK: on the next fall, sda_oe = 1 and addr_match = 1. On the following fall, sda_oe = 0, then:
    - R/W = 0: go to WR_DATA.
    - R/W = 1: pulse tx_load, capture tx_data, set sda_oe = ~tx_data[7], go to RD_DATA.
  - WR_DATA: shift on 8 rises. On the 8th rise, pulse rx_valid 1 clk later and go to WR_ACK.
  - WR_ACK: sda_oe = 1 on the next fall, 0 on the following fall, then back to WR_DATA.
  - RD_DATA: on each fall, sda_oe = ~next bit. After the 8th bit's fall, sda_oe = 0 and go to RD_ACK.
  - RD_ACK: sample sda_s on the 9th rise.
    - 0 (ACK): on the next fall, pulse tx_load and drive the new MSB.
    - 1 (NACK): pulse nack_det, go to WAIT_STOP.
  - WAIT_STOP: sda_oe = 0; ignore bits; leave only on STOP or START.
- Repeated START in any non-IDLE state: bit counter = 0, addr_match = 0, sda_oe = 0, go to ADDR, pulse start_det.
- STOP in any state: go to IDLE, sda_oe = 0, addr_match = 0, busy = 0, pulse stop_det.
- Bit counter: 4 bits, 0..8, cleared on START, at end of every ACK slot, and on reset.
- reset asserted mid-transfer: immediate return to reset values. The target then stays in IDLE until a fresh START; an in-flight byte is lost and nothing is reported.
- SDA changing while SCL is high, other than START/STOP, is impossible by construction: any such change is a START or STOP.
- busy: set on START, cleared on STOP.

Decomposition:
- Shared package i2c_pkg:
  - FSM state enum: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
  - I2C_ADDR_W = 7 and BYTE_W = 8 constants.
- One sub-module: i2c_bus_sampler. It holds the synchronizers and previous-level flops and outputs scl_rise, scl_fall, start_cond and stop_cond pulses. It is reusable by a future bus monitor.
- Storage flops are built from the existing dff cell.

Test Plan:
- Write to 0x50 with data 0xA5, 0x3C, then STOP:
  - ACK driven in the address slot and both data slots.
  - rx_valid pulses twice, with rx_data 0xA5 then 0x3C.
  - stop_det pulses once; busy returns to 0.
- Address 0x51 write: sda_oe stays 0 throughout; addr_match stays 0; rx_valid never pulses; FSM in WAIT_STOP until STOP.
- Read from 0x50, tx_data = 0xC3 then 0x0F, master ACK then NACK:
  - SDA observed 11000011 then 00001111.
  - tx_load pulses twice; nack_det pulses once after the 2nd byte.
- Write 0x50 with byte 0x12, repeated START, then read 0x50:
  - start_det pulses twice; addr_match drops at the repeated START and re-asserts at the second address ACK.
  - Read direction serves tx_data correctly.
- reset asserted during bit 4 of a write byte:
  - All outputs go to 0 next clk; no rx_valid.
  - A subsequent full write of 0x77 to 0x50 is received correctly.
- STOP injected mid-read while sda_oe = 1: sda_oe = 0 within SYNC_STAGES+2 clk of the SDA rise; FSM in IDLE.
